// File: rtl/core_piso_shift_reg_if.sv
// Handshake bundle for the PISO shift register: parallel vector in, word-serial stream out.
interface core_piso_shift_reg_if #(
    parameter int unsigned Bits   = 8,
    parameter int unsigned Length = 4
);
    logic [Bits*Length-1:0] par_data;
    logic                   par_valid;
    logic                   par_ready;
    logic [Bits-1:0]        ser_data;
    logic                   ser_valid;
    logic                   ser_ready;
    logic                   ser_last;

    modport slave (
        input  par_data, par_valid, ser_ready,
        output par_ready, ser_data, ser_valid, ser_last
    );

    modport master (
        output par_data, par_valid, ser_ready,
        input  par_ready, ser_data, ser_valid, ser_last
    );
endinterface

// File: rtl/core_piso_shift_reg.sv
// Parallel-in, serial-out shift register: loads Length words at once and streams
// them word 0 first, with valid/ready on both sides and bubble-free back-to-back loads.
module core_piso_shift_reg #(
    parameter int unsigned Bits   = 8,
    parameter int unsigned Length = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [Bits-1:0]            rst_val_i,
    core_piso_shift_reg_if.slave       bus
);
    localparam int unsigned CntW = (Length > 1) ? $clog2(Length) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]                  state_q, state_d;
    logic [CntW-1:0]             count_q, count_d;
    logic [Length-1:0][Bits-1:0] store_q, store_d;

    logic ser_valid_c;
    logic beat_c;
    logic par_ready_c;
    logic load_c;
    logic last_word_c;

    // Handshake qualifiers derived from registered state
    assign ser_valid_c = (state_q == SHIFT);
    assign last_word_c = (count_q == '0);
    assign beat_c      = ser_valid_c & bus.ser_ready;
    assign par_ready_c = (state_q == IDLE) | (beat_c & last_word_c);
    assign load_c      = bus.par_valid & par_ready_c;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        store_d = store_q;
        case (state_q)
            IDLE: begin
                if (load_c) begin
                    store_d = bus.par_data;
                    count_d = CntW'(Length - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (beat_c) begin
                    if (last_word_c && load_c) begin
                        store_d = bus.par_data;
                        count_d = CntW'(Length - 1);
                    end else begin
                        // Shift toward word 0; vacated top slot takes the fill value
                        for (int k = 0; k < int'(Length) - 1; k++) begin
                            store_d[k] = store_q[k+1];
                        end
                        store_d[Length-1] = rst_val_i;
                        if (last_word_c) begin
                            state_d = IDLE;
                        end else begin
                            count_d = count_q - CntW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            count_q <= '0;
            store_q <= {Length{rst_val_i}};
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            store_q <= store_d;
        end
    end

    assign bus.ser_data  = store_q[0];
    assign bus.ser_valid = ser_valid_c;
    assign bus.ser_last  = ser_valid_c & last_word_c;
    assign bus.par_ready = par_ready_c;

endmodule
